// File: rtl/gcd_pkg.sv
// Shared encodings for the subtractive GCD controller: state codes, mux selects, data width.
package gcd_pkg;
  localparam int unsigned DATA_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t LOADB = 2'd1;
  localparam state_t RUN   = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam logic BUS_SUB = 1'b0;
  localparam logic BUS_IN  = 1'b1;
endpackage

// File: rtl/gcd_controller_if.sv
// Control/flag bundle between the GCD controller (master) and its datapath (slave).
interface gcd_controller_if;
  logic start;
  logic lt;
  logic gt;
  logic eq;
  logic lda;
  logic ldb;
  logic sel1;
  logic sel2;
  logic selin;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, lt, gt, eq,
    output lda, ldb, sel1, sel2, selin, busy, done, err
  );

  modport slave (
    output start, lt, gt, eq,
    input  lda, ldb, sel1, sel2, selin, busy, done, err
  );
endinterface

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter with MAX_ITER compare; only compiled when GCD_CTRL_TIMEOUT_EN is defined.
`ifdef GCD_CTRL_TIMEOUT_EN
module gcd_iter_cnt #(
  parameter int unsigned MAX_ITER = 65535,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_max
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_max = (r_cnt == CNT_W'(MAX_ITER));
endmodule
`endif

// File: rtl/gcd_controller.sv
// Sequencing FSM for the 16-bit subtractive GCD datapath; Mealy outputs.
// Optional iteration timeout with err pulse: define GCD_CTRL_TIMEOUT_EN.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned MAX_ITER = 65535,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  gcd_controller_if.master bus
);
  state_t r_state;
  state_t w_next;
  logic   w_lda, w_ldb, w_sel1, w_sel2, w_selin, w_busy, w_done;
  logic   w_max;

  if (64'(MAX_ITER) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("CNT_W too narrow to hold MAX_ITER");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_lda   = 1'b0;
    w_ldb   = 1'b0;
    w_sel1  = SEL_A;
    w_sel2  = SEL_A;
    w_selin = BUS_SUB;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_selin = BUS_IN;
          w_lda   = 1'b1;
          w_next  = LOADB;
        end
      end
      LOADB: begin
        w_busy  = 1'b1;
        w_selin = BUS_IN;
        w_ldb   = 1'b1;
        w_next  = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        // eq wins over the timeout so a job finishing on the last allowed step is not flagged
        if (bus.eq) begin
          w_next = DONE;
        end else if (w_max) begin
          w_next = DONE;
        end else if (bus.gt) begin
          w_sel1 = SEL_A;
          w_sel2 = SEL_B;
          w_lda  = 1'b1;
        end else if (bus.lt) begin
          w_sel1 = SEL_B;
          w_sel2 = SEL_A;
          w_ldb  = 1'b1;
        end
      end
      default: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

`ifdef GCD_CTRL_TIMEOUT_EN
  logic w_clr, w_inc, r_tmo;

  assign w_clr = (r_state == IDLE) && bus.start;
  assign w_inc = (r_state == RUN) && (w_lda || w_ldb);

  gcd_iter_cnt #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) u_iter_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_max (w_max)
  );

  // Remembers why RUN exited so err can accompany the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_tmo <= 1'b0;
    else if ((r_state == RUN) && !bus.eq && w_max)   r_tmo <= 1'b1;
    else if (r_state == DONE)                        r_tmo <= 1'b0;
  end

  assign bus.err = (r_state == DONE) && r_tmo;
`else
  assign w_max   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.lda   = w_lda;
  assign bus.ldb   = w_ldb;
  assign bus.sel1  = w_sel1;
  assign bus.sel2  = w_sel2;
  assign bus.selin = w_selin;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller driving a behavioural GCD datapath.
module tb_gcd_controller;
  import gcd_pkg::*;

`ifdef GCD_CTRL_TIMEOUT_EN
  localparam int unsigned TB_MAX = 8;
`else
  localparam int unsigned TB_MAX = 65535;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_controller_if bus();

  gcd_controller #(.MAX_ITER(TB_MAX), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DATA_W-1:0] data_in, r_a, r_b, w_sub, w_bus;
  assign w_sub  = (bus.sel1 ? r_b : r_a) - (bus.sel2 ? r_b : r_a);
  assign w_bus  = bus.selin ? data_in : w_sub;
  assign bus.lt = r_a < r_b;
  assign bus.gt = r_a > r_b;
  assign bus.eq = r_a == r_b;
  always @(posedge clk) begin
    if (bus.lda) r_a <= w_bus;
    if (bus.ldb) r_b <= w_bus;
  end

  typedef struct {
    int res;
    int err;
    int done_edge;
    int loads;
    bit chk_val;
    int gap;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.lda, bus.ldb, bus.sel1, bus.sel2, bus.selin, bus.busy, bus.done, bus.err});
  endfunction

  // Monitor
  int cyc, busy_n, loads, since_done, acc_gap;
  bit in_job;
  initial begin
    in_job = 0; cyc = 0; busy_n = 0; loads = 0; since_done = 1000; acc_gap = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_job = 0;
      end else begin
        if (in_job) cyc++;
        since_done++;
        if (bus.lda && bus.selin && !bus.busy) begin
          in_job = 1; cyc = 0; busy_n = 0; loads = 0; acc_gap = since_done;
        end
        if (in_job && bus.busy) busy_n++;
        if (in_job && bus.busy && !bus.selin && (bus.lda || bus.ldb)) loads++;
        if (bus.done) begin
          if (q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("done_edge", cyc - 1, e.done_edge);
            check("busy_cycles", busy_n, e.done_edge);
            check("run_loads", loads, e.loads);
            check("err", int'(bus.err), e.err);
            if (e.chk_val) begin
              check("aout", int'(r_a), e.res);
              check("bout", int'(r_b), e.res);
            end
            if (e.gap >= 0) check("idle_gap", acc_gap, e.gap);
          end
          in_job = 0;
          since_done = 0;
        end
      end
    end
  end

  task automatic push(input int res, input int err, input int de, input int ld,
                      input bit chk, input int gap);
    exp_t e;
    e.res = res; e.err = err; e.done_edge = de; e.loads = ld; e.chk_val = chk; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic launch(input int a, input int b);
    @(posedge clk); #1;
    bus.start = 1'b1; data_in = DATA_W'(a);
    @(posedge clk); #1;
    bus.start = 1'b0; data_in = DATA_W'(b);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  int seq[8];

  initial begin
    bus.start = 1'b0;
    data_in   = '0;
    #3;
    check("reset_outputs", outs(), 0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // 48,18 -> 6 in four subtractions
    push(6, 0, 6, 4, 1, -1);
    launch(48, 18);
    wait_empty(50, "t1_timeout");

    // equal operands: no subtraction
    push(25, 0, 2, 0, 1, -1);
    launch(25, 25);
    wait_empty(50, "t2_timeout");

    // async reset in RUN aborts; next job still correct
    launch(100, 7);
    repeat (3) @(posedge clk);
    #1;
    check("t5_busy_before_rst", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_async_outputs", outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(3, 0, 4, 2, 1, -1);
    launch(9, 6);
    wait_empty(50, "t5_timeout");

    // start held high across two jobs; ignored outside IDLE
    push(4, 0, 4, 2, 1, -1);
    push(7, 0, 4, 2, 1, 1);
    seq = '{12, 8, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 21, 14};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      data_in   = DATA_W'(seq[i]);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_empty(50, "t6_timeout");

`ifdef GCD_CTRL_TIMEOUT_EN
    // zero operand times out after MAX_ITER=8 loads; err with done
    push(0, 1, 10, 8, 0, -1);
    launch(0, 5);
    wait_empty(60, "t4_timeout");
    push(3, 0, 4, 2, 1, -1);
    launch(9, 6);
    wait_empty(50, "t4_next_timeout");
`else
    // long run: 1,65535 needs 65534 subtractions
    push(1, 0, 65536, 65534, 1, -1);
    launch(1, 65535);
    wait_empty(70000, "t3_timeout");
`endif

    repeat (3) @(posedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
